hba_serial_bridge: RTL
======================

// Module: hba_serial_bridge
// PURPOSE
//  Byte-stream to HBA bus master bridge, second generation of the serial FPGA bridge.
//  Decodes framed commands from a byte source (UART RX) and runs burst reads/writes on the HBA bus.
//  Returns echo/data/status bytes to a byte sink (UART TX).
//  Adds: explicit 8-bit burst length (1..256), fixed-address mode, bus timeout with NACK,
//  RX inter-byte timeout with frame abort, and real request/grant arbitration.
// PARAMETERS
//  DBUS_WIDTH        8     HBA data width; must be 8
//  PERIPH_ADDR_WIDTH 4     peripheral address bits; 1..6, taken from CMD[PERIPH_ADDR_WIDTH-1:0]
//  REG_ADDR_WIDTH    8     register address bits; must be 8
//  BUS_TIMEOUT       255   hba_clk cycles with master_select high and no xferack -> bus error
//  RX_IDLE_TIMEOUT   65535 hba_clk cycles between bytes of an open frame -> abort to IDLE
// PORTS
//  hba_clk        in   1   clock
//  hba_reset_n    in   1   asynchronous, active-low reset
//  rx_data        in   8   received byte
//  rx_valid       in   1   rx_data valid; consumed when rx_valid & rx_ready
//  rx_ready       out  1   bridge accepts a byte this cycle
//  tx_data        out  8   byte to transmit
//  tx_valid       out  1   tx_data valid; held stable until tx_ready
//  tx_ready       in   1   sink accepts tx_data this cycle
//  hba_mgrant     in   1   bus granted to this master
//  hba_xferack    in   1   slave completed the current transfer
//  hba_dbus       in   8   read data, sampled on hba_xferack
//  master_request out  1   bus request
//  master_abus    out  PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH  {periph,reg}; 0 when master_select low
//  master_rnw     out  1   1=read, 0=write; 0 when master_select low
//  master_select  out  1   transfer in progress
//  master_dbus    out  8   write data; 0 when master_select low
//  busy           out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; err flag, counters and address cleared. A reset
//   mid-burst drops master_select and master_request immediately (asynchronous).
//  Frame: CMD, RA, LEN, then LEN+1 data bytes on writes.
//   CMD[7] = rnw; CMD[6] = fixed (1 = no RA increment); CMD[5:PERIPH_ADDR_WIDTH] are ignored.
//  Writes: after the last transfer, send 0xAC if there was no error, otherwise 0x56.
//  Reads: echo CMD, RA, LEN, then send LEN+1 data bytes, then status 0xAC/0x56.
//  FSM states and transitions:
//   IDLE -> GET_RA -> GET_LEN
//   GET_LEN -> ECHO_CMD -> ECHO_RA -> ECHO_LEN -> BUS_REQ      (reads)
//   GET_LEN -> GET_DATA -> BUS_REQ                              (writes)
//   BUS_REQ -> BUS_XFER
//   BUS_XFER -> SEND_DATA (read) | GET_DATA or STATUS (write)
//   SEND_DATA -> BUS_REQ | STATUS
//   STATUS -> IDLE
//  rx_ready is high only in IDLE, GET_RA, GET_LEN and GET_DATA.
//   Each state consumes exactly one byte per handshake.
//  tx_valid is high only in the ECHO_*, SEND_DATA and STATUS states.
//   The state advances on the cycle where tx_valid & tx_ready.
//  BUS_REQ: master_request is raised. It stays high from the first BUS_REQ of a frame
//   until STATUS entry, so the whole burst is held.
//   On the first cycle with hba_mgrant high -> BUS_XFER.
//  BUS_XFER: master_select, master_abus, master_rnw and master_dbus are registered outputs,
//   driven starting the cycle after BUS_XFER entry.
//   On hba_xferack: capture hba_dbus, drop master_select and the bus fields to 0 on the next cycle.
//   A minimum of one idle cycle separates transfers.
//  Bus timeout: BUS_TIMEOUT cycles of select with no ack end the transfer.
//   Select is dropped, the err flag is set, read data is replaced with 0x00,
//   and the burst continues so byte counts stay framed.
//  Register address: RA increments by 1 after each transfer unless fixed is set;
//   it wraps 0xFF -> 0x00. The peripheral field never changes within a frame.
//  Count: 9-bit remaining counter loaded with LEN+1. LEN=0xFF gives 256 transfers.
//  RX idle timeout: applies only in GET_RA, GET_LEN and GET_DATA.
//   On expiry -> IDLE with no status byte; request is dropped.
//   A bus transfer already started is never cut short.
//  Simultaneous hba_xferack and timeout expiry: the ack wins and no error is flagged.
//  A stray hba_xferack outside BUS_XFER is ignored.
// TESTING
//  1. Write CMD=0x03 RA=0x10 LEN=0x01 D=0xA5,0x5A; grant after 2 cycles, ack after 1 ->
//     bus writes 0x310=A5 then 0x311=5A, then tx 0xAC.
//  2. Read CMD=0x82 RA=0x20 LEN=0x02, slave returns 11,22,33 ->
//     tx 82 20 02 11 22 33 AC, abus 0x220..0x222.
//  3. Fixed read CMD=0xC5 RA=0x07 LEN=0x03 -> four reads all at abus 0x507; status 0xAC.
//  4. Read RA=0xFF LEN=0x01 at periph 1 -> abus 0x1FF then 0x100 (wrap, periph unchanged).
//  5. Write where slave never acks the second byte ->
//     select drops after BUS_TIMEOUT cycles, burst completes, tx 0x56.
//  6. Send CMD, RA, then stall RX_IDLE_TIMEOUT cycles -> busy falls, no tx.
//     The next frame decodes normally. Also assert hba_reset_n mid-BUS_XFER ->
//     all outputs 0 the same cycle.

Source files
------------

// File: rtl/hba_serial_bridge_if.sv
// rtl/hba_serial_bridge_if.sv - byte-stream and HBA bus signal bundle for hba_serial_bridge
// Ports (master = bridge side):
//   rx_data/rx_valid -> bridge, rx_ready <- bridge          received byte stream
//   tx_data/tx_valid <- bridge, tx_ready -> bridge          transmitted byte stream
//   hba_mgrant/hba_xferack/hba_dbus -> bridge               arbiter grant, slave ack, read data
//   master_request/abus/rnw/select/dbus <- bridge           bus request and transfer fields
//   busy <- bridge                                          bridge is not idle
interface hba_serial_bridge_if #(
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8
);
  logic [7:0]                                  rx_data;
  logic                                        rx_valid;
  logic                                        rx_ready;
  logic [7:0]                                  tx_data;
  logic                                        tx_valid;
  logic                                        tx_ready;
  logic                                        hba_mgrant;
  logic                                        hba_xferack;
  logic [DBUS_WIDTH-1:0]                       hba_dbus;
  logic                                        master_request;
  logic [PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH-1:0] master_abus;
  logic                                        master_rnw;
  logic                                        master_select;
  logic [DBUS_WIDTH-1:0]                       master_dbus;
  logic                                        busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, hba_mgrant, hba_xferack, hba_dbus,
    output rx_ready, tx_data, tx_valid, master_request, master_abus,
           master_rnw, master_select, master_dbus, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, hba_mgrant, hba_xferack, hba_dbus,
    input  rx_ready, tx_data, tx_valid, master_request, master_abus,
           master_rnw, master_select, master_dbus, busy
  );
endinterface

// File: rtl/hba_serial_bridge.sv
// rtl/hba_serial_bridge.sv - byte-stream framed command to HBA burst bus master bridge
// Ports:
//   hba_clk      in  clock
//   hba_reset_n  in  asynchronous active-low reset
//   bus          hba_serial_bridge_if.master: rx/tx byte streams, HBA grant/ack/read data,
//                request/select/address/rnw/write data, busy
// Frame: CMD{rnw,fixed,-,periph}, RA, LEN, then LEN+1 data bytes for writes.
// Reads echo CMD/RA/LEN, return LEN+1 bytes, then a status byte (0xAC ok, 0x56 error).
module hba_serial_bridge #(
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int BUS_TIMEOUT       = 255,
  parameter int RX_IDLE_TIMEOUT   = 65535
) (
  input logic                 hba_clk,
  input logic                 hba_reset_n,
  hba_serial_bridge_if.master bus
);
  localparam int BTW = $clog2(BUS_TIMEOUT + 1);
  localparam int RTW = $clog2(RX_IDLE_TIMEOUT + 1);
  localparam int AW  = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH;

  typedef enum logic [3:0] {
    IDLE, GET_RA, GET_LEN, ECHO_CMD, ECHO_RA, ECHO_LEN,
    GET_DATA, BUS_REQ, BUS_XFER, SEND_DATA, STATUS
  } state_t;

  state_t                    state, next_state;
  logic [7:0]                cmd_q, len_q;
  logic [REG_ADDR_WIDTH-1:0] ra_q;
  logic [8:0]                cnt_q;
  logic [DBUS_WIDTH-1:0]     wdata_q, rdata_q;
  logic                      err_q, req_q, rdy_en_q;
  logic                      sel_q, rnw_q;
  logic [AW-1:0]             abus_q;
  logic [DBUS_WIDTH-1:0]     dbus_q;
  logic [BTW-1:0]            bus_tmr;
  logic [RTW-1:0]            rx_tmr;

  logic rx_hs, tx_hs, rx_wait, rx_to, ack, bus_to, xfer_done;

  assign rx_hs     = bus.rx_valid & bus.rx_ready;
  assign tx_hs     = bus.tx_valid & bus.tx_ready;
  assign rx_wait   = (state == GET_RA) || (state == GET_LEN) || (state == GET_DATA);
  assign rx_to     = rx_wait && !rx_hs && (rx_tmr == RTW'(RX_IDLE_TIMEOUT - 1));
  // Ack only counts while select is actually driven; it beats a same-cycle timeout.
  assign ack       = (state == BUS_XFER) && sel_q && bus.hba_xferack;
  assign bus_to    = (state == BUS_XFER) && sel_q && !bus.hba_xferack &&
                     (bus_tmr == BTW'(BUS_TIMEOUT - 1));
  assign xfer_done = ack || bus_to;

  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) state <= IDLE;
    else              state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (rx_hs) next_state = GET_RA;
      GET_RA:    if (rx_hs) next_state = GET_LEN;
                 else if (rx_to) next_state = IDLE;
      GET_LEN:   if (rx_hs) next_state = cmd_q[7] ? ECHO_CMD : GET_DATA;
                 else if (rx_to) next_state = IDLE;
      ECHO_CMD:  if (tx_hs) next_state = ECHO_RA;
      ECHO_RA:   if (tx_hs) next_state = ECHO_LEN;
      ECHO_LEN:  if (tx_hs) next_state = BUS_REQ;
      GET_DATA:  if (rx_hs) next_state = BUS_REQ;
                 else if (rx_to) next_state = IDLE;
      BUS_REQ:   if (bus.hba_mgrant) next_state = BUS_XFER;
      BUS_XFER:  if (xfer_done) begin
                   if (cmd_q[7])            next_state = SEND_DATA;
                   else if (cnt_q == 9'd1)  next_state = STATUS;
                   else                     next_state = GET_DATA;
                 end
      SEND_DATA: if (tx_hs) next_state = (cnt_q == 9'd0) ? STATUS : BUS_REQ;
      STATUS:    if (tx_hs) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.rx_ready = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    case (state)
      // rdy_en_q keeps rx_ready low while reset is asserted even though IDLE accepts bytes.
      IDLE, GET_RA, GET_LEN, GET_DATA: bus.rx_ready = rdy_en_q;
      ECHO_CMD:  begin bus.tx_valid = 1'b1; bus.tx_data = cmd_q;   end
      ECHO_RA:   begin bus.tx_valid = 1'b1; bus.tx_data = ra_q;    end
      ECHO_LEN:  begin bus.tx_valid = 1'b1; bus.tx_data = len_q;   end
      SEND_DATA: begin bus.tx_valid = 1'b1; bus.tx_data = rdata_q; end
      STATUS:    begin bus.tx_valid = 1'b1; bus.tx_data = err_q ? 8'h56 : 8'hAC; end
      default:   ;
    endcase
  end

  assign bus.busy           = (state != IDLE);
  assign bus.master_request = req_q;
  assign bus.master_select  = sel_q;
  assign bus.master_abus    = abus_q;
  assign bus.master_rnw     = rnw_q;
  assign bus.master_dbus    = dbus_q;

  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      cmd_q <= '0; len_q <= '0; ra_q <= '0; cnt_q <= '0;
      wdata_q <= '0; rdata_q <= '0; err_q <= 1'b0; req_q <= 1'b0; rdy_en_q <= 1'b0;
      sel_q <= 1'b0; rnw_q <= 1'b0; abus_q <= '0; dbus_q <= '0;
      bus_tmr <= '0; rx_tmr <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      rx_tmr   <= (rx_wait && !rx_hs) ? rx_tmr + 1'b1 : '0;

      if (state == IDLE && rx_hs)     begin cmd_q <= bus.rx_data; err_q <= 1'b0; end
      if (state == GET_RA && rx_hs)   ra_q <= bus.rx_data;
      if (state == GET_LEN && rx_hs)  begin len_q <= bus.rx_data; cnt_q <= {1'b0, bus.rx_data} + 9'd1; end
      if (state == GET_DATA && rx_hs) wdata_q <= bus.rx_data;

      // Request is held across the whole burst, including the gaps spent collecting write bytes.
      if (next_state == BUS_REQ)                           req_q <= 1'b1;
      else if (next_state == STATUS || next_state == IDLE) req_q <= 1'b0;

      if (state == BUS_XFER) begin
        if (!sel_q) begin
          sel_q   <= 1'b1;
          abus_q  <= {cmd_q[PERIPH_ADDR_WIDTH-1:0], ra_q};
          rnw_q   <= cmd_q[7];
          dbus_q  <= cmd_q[7] ? '0 : wdata_q;
          bus_tmr <= '0;
        end else if (xfer_done) begin
          sel_q   <= 1'b0;
          abus_q  <= '0;
          rnw_q   <= 1'b0;
          dbus_q  <= '0;
          rdata_q <= ack ? bus.hba_dbus : '0;
          if (bus_to) err_q <= 1'b1;
          cnt_q   <= cnt_q - 9'd1;
          if (!cmd_q[6]) ra_q <= ra_q + 1'b1;
        end else begin
          bus_tmr <= bus_tmr + 1'b1;
        end
      end
    end
  end
endmodule
